// File: rtl/wallace_mul_arb.sv
// Round-robin issue controller that shares one pipelined 8x8 multiplier among NREQ requesters.
// Optional feature macro WALLACE_MUL_ARB_CNT_EN adds the issue_cnt and inflight observation ports.
module wallace_mul_arb #(
  parameter int NREQ     = 4,
  parameter int PIPE_LAT = 4,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [16:0]       mul_p,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [16:0]       rsp_p,
  output logic [IDW-1:0]    rsp_id,
  input  logic              flush,
  output logic              idle
`ifdef WALLACE_MUL_ARB_CNT_EN
  ,
  output logic [15:0]       issue_cnt,
  output logic [3:0]        inflight
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  logic [IDW-1:0]      ptr;
  logic [PIPE_LAT-1:0] tag_v;
  logic [IDW-1:0]      tag_id [PIPE_LAT];
  logic                ret_v;
  logic [IDW-1:0]      ret_id;

  logic [IDW-1:0]      gnt_id;
  logic                gnt_any;
  logic                accept;
  logic                busy;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s -= NREQ;
    return IDW'(s);
  endfunction

  // NOTE: every always_comb output gets a default first so no path through the block infers a latch.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[wrap_add(ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_id  = wrap_add(ptr, k);
      end
    end
  end

  // A flush request wins over any same-cycle request, and DRAIN never grants.
  always_comb begin
    req_ready = '0;
    if (gnt_any && state != DRAIN && !flush) req_ready[gnt_id] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);
  // ret_v is the result-capture slot between the last tag stage and rsp_*; it is still in flight.
  assign busy   = (|tag_v) | ret_v;
  assign idle   = (state == IDLE) && !busy;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      tag_v     <= '0;
      ret_v     <= 1'b0;
      rsp_valid <= '0;
      rsp_p     <= '0;
      rsp_id    <= '0;
    end else begin
      if (accept) begin
        mul_a <= req_a[8*gnt_id +: 8];
        mul_b <= req_b[8*gnt_id +: 8];
        ptr   <= wrap_add(gnt_id, 1);
      end

      for (int i = PIPE_LAT-1; i > 0; i--) tag_v[i] <= tag_v[i-1];
      tag_v[0] <= accept;
      ret_v    <= tag_v[PIPE_LAT-1];

      rsp_valid <= ret_v ? (NREQ'(1) << ret_id) : '0;
      if (ret_v) begin
        rsp_p  <= mul_p;
        rsp_id <= ret_id;
      end

      unique case (state)
        IDLE:    if (flush) state <= DRAIN;
                 else if (accept) state <= RUN;
        RUN:     if (flush) state <= DRAIN;
                 else if (!busy && !accept) state <= IDLE;
        DRAIN:   if (!busy && !flush) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the id pipeline is not reset; each id is only ever read while its tag_v bit is set.
  always_ff @(posedge clk) begin
    for (int i = PIPE_LAT-1; i > 0; i--) tag_id[i] <= tag_id[i-1];
    tag_id[0] <= gnt_id;
    ret_id    <= tag_id[PIPE_LAT-1];
  end

`ifdef WALLACE_MUL_ARB_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) issue_cnt <= '0;
    else        issue_cnt <= issue_cnt + 16'(accept);
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) inflight = inflight + 4'(tag_v[i]);
  end
`endif

endmodule

// File: tb/tb_wallace_mul_arb.sv
// Self-checking bench for wallace_mul_arb: directed vectors plus hand-written stream, flush,
// reset and pointer-wrap sequences against a behavioural 4-stage multiplier.
module tb_wallace_mul_arb;

  localparam int NREQ     = 4;
  localparam int PIPE_LAT = 4;
  localparam int IDW      = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [16:0]       mul_p;
  logic [NREQ-1:0]   rsp_valid;
  logic [16:0]       rsp_p;
  logic [IDW-1:0]    rsp_id;
  logic              flush;
  logic              idle;
`ifdef WALLACE_MUL_ARB_CNT_EN
  logic [15:0]       issue_cnt;
  logic [3:0]        inflight;
`endif

  wallace_mul_arb #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .flush     (flush),
    .idle      (idle)
`ifdef WALLACE_MUL_ARB_CNT_EN
    ,
    .issue_cnt (issue_cnt),
    .inflight  (inflight)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: PIPE_LAT register stages from operand change to mul_p.
  logic [16:0] p_pipe [PIPE_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) p_pipe[i] <= '0;
    end else begin
      p_pipe[0] <= 17'(mul_a) * 17'(mul_b);
      for (int i = 1; i < PIPE_LAT; i++) p_pipe[i] <= p_pipe[i-1];
    end
  end
  assign mul_p = p_pipe[PIPE_LAT-1];

  // Event monitor: grant edges and response edges, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          g_id[$];
  int          g_edge[$];
  int          r_id[$];
  int          r_p[$];
  int          r_vld[$];
  int          r_edge[$];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          g_id.push_back(i);
          g_edge.push_back(cyc + 1);
        end
      end
      if (rsp_valid != '0) begin
        r_id.push_back(int'(rsp_id));
        r_p.push_back(int'(rsp_p));
        r_vld.push_back(int'(rsp_valid));
        r_edge.push_back(cyc);
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    g_id.delete(); g_edge.delete();
    r_id.delete(); r_p.delete(); r_vld.delete(); r_edge.delete();
  endtask

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(n < budget), 1);
  endtask

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [16:0] p;
    logic [3:0]  vld;
  } vec_t;

  task automatic run_vec(input int k, input vec_t v);
    int n;
    bit got;
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    set_ops(v.id, v.a, v.b);
    #1;
    check($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(v.vld));
    step();
    req_valid = '0;
    n   = 0;
    got = 0;
    while (!got && n < 10) begin
      step();
      n++;
      if (rsp_valid != '0) got = 1;
    end
    check($sformatf("vec%0d_latency", k), n, PIPE_LAT + 1);
    check($sformatf("vec%0d_rsp_valid", k), 32'(rsp_valid), 32'(v.vld));
    check($sformatf("vec%0d_rsp_p", k), 32'(rsp_p), 32'(v.p));
    check($sformatf("vec%0d_rsp_id", k), 32'(rsp_id), v.id);
    check($sformatf("vec%0d_idle_on_strobe", k), 32'(idle), 0);
    step();
    check($sformatf("vec%0d_strobe_drop", k), 32'(rsp_valid), 0);
    check($sformatf("vec%0d_rsp_hold", k), 32'(rsp_p), 32'(v.p));
    check($sformatf("vec%0d_idle_after", k), 32'(idle), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  int   fedge;
  int   peak;
  logic any_ready;

  initial begin
    // Last vector is requester 3, which leaves the pointer at 0 for the stream test.
    vecs[0] = '{id: 2, a: 8'd255, b: 8'd255, p: 17'd65025, vld: 4'b0100};
    vecs[1] = '{id: 0, a: 8'd0,   b: 8'd200, p: 17'd0,     vld: 4'b0001};
    vecs[2] = '{id: 1, a: 8'd255, b: 8'd1,   p: 17'd255,   vld: 4'b0010};
    vecs[3] = '{id: 0, a: 8'd1,   b: 8'd1,   p: 17'd1,     vld: 4'b0001};
    vecs[4] = '{id: 3, a: 8'd16,  b: 8'd16,  p: 17'd256,   vld: 4'b1000};
    vecs[5] = '{id: 3, a: 8'd128, b: 8'd2,   p: 17'd256,   vld: 4'b1000};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_p", 32'(rsp_p), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_idle", 32'(idle), 1);
    #3 rst_n = 1'b1;
    step();

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // All four requesters continuously valid for 8 cycles.
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 1), 8'd3);
    clear_log();
    req_valid = 4'hF;
    repeat (8) step();
    req_valid = '0;
    wait_idle("stream_drain", 40);
    check("stream_grant_count", g_id.size(), 8);
    check("stream_rsp_count", r_id.size(), 8);
    for (int k = 0; k < 8 && k < g_id.size() && k < r_id.size(); k++) begin
      check($sformatf("stream_grant%0d_id", k), g_id[k], k % 4);
      check($sformatf("stream_grant%0d_edge", k), g_edge[k] - g_edge[0], k);
      check($sformatf("stream_rsp%0d_id", k), r_id[k], k % 4);
      check($sformatf("stream_rsp%0d_p", k), r_p[k], 3 * (k % 4 + 1));
      check($sformatf("stream_rsp%0d_vld", k), r_vld[k], 1 << (k % 4));
      check($sformatf("stream_rsp%0d_latency", k), r_edge[k] - g_edge[k], PIPE_LAT + 1);
    end

    // Flush while all requesters are still valid.
    clear_log();
    req_valid = 4'hF;
    repeat (3) step();
    flush = 1'b1;
    fedge = cyc + 1;
    #1;
    check("flush_ready_same_cycle", 32'(req_ready), 0);
    any_ready = 1'b0;
    repeat (8) begin
      step();
      any_ready = any_ready | (|req_ready);
    end
    check("flush_ready_held_low", 32'(any_ready), 0);
    check("flush_idle_while_held", 32'(idle), 0);
    flush     = 1'b0;
    req_valid = '0;
    step();
    check("flush_idle_after_release", 32'(idle), 1);
    check("flush_grant_count", g_id.size(), 3);
    check("flush_rsp_count", r_id.size(), 3);
    for (int k = 0; k < 3 && k < r_id.size(); k++)
      check($sformatf("flush_rsp%0d_id", k), r_id[k], k);
    if (r_edge.size() > 0)
      check("flush_last_rsp_bound", 32'(r_edge[r_edge.size()-1] - fedge <= PIPE_LAT + 1), 1);

    // Reset pulse with three operations in flight (pointer is 3 here, so grants 3,0,1).
    clear_log();
    req_valid = 4'hF;
    repeat (3) step();
    req_valid = '0;
    rst_n     = 1'b0;
    #2;
    check("midrst_mul_a", 32'(mul_a), 0);
    check("midrst_mul_b", 32'(mul_b), 0);
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_rsp_p", 32'(rsp_p), 0);
    check("midrst_rsp_id", 32'(rsp_id), 0);
    check("midrst_req_ready", 32'(req_ready), 0);
    check("midrst_idle", 32'(idle), 1);
    #1 rst_n = 1'b1;
    repeat (10) step();
    check("midrst_pre_grants", g_id.size(), 3);
    check("midrst_no_rsp", r_id.size(), 0);
    req_valid = 4'hF;
    #1;
    check("midrst_first_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    wait_idle("midrst_drain", 20);

    // Pointer wrap: requester 3, then 0, then 3 (pointer starts at 1).
    set_ops(3, 8'd7, 8'd9);
    set_ops(0, 8'd5, 8'd5);
    clear_log();
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    wait_idle("wrap_drain", 20);
    check("wrap_grant_count", g_id.size(), 3);
    check("wrap_rsp_count", r_id.size(), 3);
    if (g_id.size() == 3 && r_id.size() == 3) begin
      check("wrap_grant0", g_id[0], 3);
      check("wrap_grant1", g_id[1], 0);
      check("wrap_grant2", g_id[2], 3);
      check("wrap_no_gap", g_edge[2] - g_edge[0], 2);
      check("wrap_rsp0_p", r_p[0], 63);
      check("wrap_rsp1_p", r_p[1], 25);
      check("wrap_rsp2_id", r_id[2], 3);
      check("wrap_rsp_no_gap", r_edge[2] - r_edge[0], 2);
    end

`ifdef WALLACE_MUL_ARB_CNT_EN
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    peak      = 0;
    req_valid = 4'hF;
    repeat (65537) begin
      step();
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    req_valid = '0;
    #1;
    check("cnt_issue_wrap", 32'(issue_cnt), 1);
    check("cnt_inflight_peak", peak, PIPE_LAT);
    wait_idle("cnt_drain", 20);
    check("cnt_inflight_empty", 32'(inflight), 0);
    clear_log();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wallace_mul_arb.md
# wallace_mul_arb

Round-robin arbiter and issue controller that shares one pipelined 8x8 Wallace multiplier among `NREQ` requesters. Each cycle it grants at most one requester, registers that requester's operands onto the multiplier inputs, and tracks the requester ID through a tag shift register matched to the multiplier's pipeline depth. It returns the product to the correct requester with a one-cycle valid strobe. A flush/drain FSM lets the system quiesce the multiplier before reconfiguration or power-down.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `PIPE_LAT`, 4: multiplier pipeline depth in clock edges, from operand change to `mul_p` valid; 1..8.
- `IDW`, 2: ID width, equal to clog2(`NREQ`).
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: per-requester operand-valid.
- `req_a`  in  8*NREQ: packed multiplicand; requester i is at [8i+7:8i].
- `req_b`  in  8*NREQ: packed multiplier, same packing.
- `req_ready`  out  NREQ: one-hot grant; acceptance occurs on `req_valid[i] & req_ready[i]`.
- `mul_a`  out  8: registered operand to multiplier `a`.
- `mul_b`  out  8: registered operand to multiplier `b`.
- `mul_p`  in  17: multiplier product.
- `rsp_valid`  out  NREQ: one-hot, one-cycle result strobe.
- `rsp_p`  out  17: registered product.
- `rsp_id`  out  IDW: requester index of `rsp_p`.
- `flush`  in  1: level request to stop issuing and drain.
- `idle`  out  1: high when no operation is in flight and the FSM is in IDLE.

## Operation
- **Arbitration**
  - Round-robin pointer `ptr` has reset value 0.
  - Grant goes to the first i with `req_valid[i]=1`, searching from `ptr` upward with wrap.
  - `req_ready` is combinational from `req_valid`, `ptr` and the FSM state.
  - All `req_ready` bits are 0 in DRAIN.
  - On acceptance, `ptr` becomes (granted+1) mod `NREQ`. `ptr` is unchanged when nothing is accepted.
- **Requester rule:** a requester holds `req_valid` and its operands stable until it is accepted. There is no backpressure on responses, and the multiplier never stalls.
- **Issue**
  - On acceptance, `mul_a`/`mul_b` load the granted operands.
  - A tag {v=1, id} enters stage 0 of a `PIPE_LAT`-deep tag shift register.
  - With no acceptance, `mul_a`/`mul_b` hold their values and a tag with v=0 enters.
- **Return**
  - When the tag at the last stage has v=1, `rsp_p` latches `mul_p` and `rsp_id` latches the tag's id.
  - On that same edge, `rsp_valid` is set to one-hot(id). Otherwise `rsp_valid` is 0.
  - `rsp_p` and `rsp_id` hold their values between strobes.
- **Arithmetic:** products pass through unmodified. `mul_p[16]` is expected to be 0 for 8x8 operands and is forwarded as-is.
- **FSM states: IDLE, RUN, DRAIN.**
  - IDLE -> RUN on any acceptance.
  - RUN -> IDLE when no tag has v=1 and there is no acceptance this cycle.
  - RUN/IDLE -> DRAIN when `flush`=1. `flush` has priority over a same-cycle request: no grant is given in that cycle.
  - DRAIN -> IDLE when all tags have v=0 and `flush`=0. DRAIN is held while `flush` stays high.
  - `idle` = (state==IDLE) and all tags have v=0.
- **Reset**
  - All outputs are 0, all tags have v=0, `ptr`=0 and the state is IDLE. `idle` is 1 after reset.
  - Reset during operation discards in-flight tags; no `rsp_valid` fires for them.

## Timing
- An acceptance at edge E drives `mul_a`/`mul_b` after E.
- `mul_p` is valid after E+`PIPE_LAT`.
- `rsp_valid`/`rsp_p` are registered at E+`PIPE_LAT`+1, giving a latency of `PIPE_LAT`+1 edges.
- Throughput is one product per cycle.
- Back-to-back accepts return back-to-back responses in issue order.
- With `NREQ` requesters all continuously valid, each is granted exactly once every `NREQ` cycles.
- Assertion of `flush` suppresses grants in that same cycle. The last response arrives at most `PIPE_LAT`+1 edges later.

## Configuration
- `WALLACE_MUL_ARB_CNT_EN`
  - **Defined:** adds output `issue_cnt` (16 bits), which increments on every acceptance, wraps at 65535->0 and resets to 0. Also adds output `inflight` (4 bits), the count of tags with v=1.
  - **Undefined:** these ports and their logic are absent.
  - Arbitration and timing are identical in both builds.

## Test plan
- **Single request:** requester 2 sends a=255, b=255 with `PIPE_LAT`=4. Required: `rsp_valid`=4'b0100, `rsp_p`=65025 and `rsp_id`=2, exactly 5 edges after acceptance; `idle` returns to 1 on the next cycle.
- **All four requesters valid for 8 cycles**, requester i sending a=i+1, b=3. Required: grants in order 0,1,2,3,0,1,2,3; responses in the same order with values 3,6,9,12 repeating.
- **Flush during streaming:** `flush` rises while requesters are valid. Required: `req_ready` is 0 from that cycle; the in-flight responses (at most 4) still arrive; `idle`=1 once `flush` is released after the drain.
- **Reset mid-stream:** `rst_n` is pulsed low with 3 tags in flight. Required: no `rsp_valid` thereafter; all outputs are 0; the first grant after release goes to requester 0.
- **Pointer wrap:** only requester 3, then requester 0, then requester 3 valid. Required: grants 3, 0, 3 with no idle gap between them.
- **With `WALLACE_MUL_ARB_CNT_EN` defined:** 65537 acceptances are issued. Required: `issue_cnt`=1; `inflight` peaks at `PIPE_LAT` under continuous issue.
